// File: rtl/imem_loader.sv
// +--------------------------------------------------------------------------+
// | imem_loader : byte-stream program loader for the instruction memory;      |
// | holds the CPU in reset until a checksum-verified image has been written.  |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  in_valid_i,
  input  logic [7:0]            in_data_i,
  output logic                  in_ready_o,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [31:0]           imem_wdata_o,
  output logic                  cpu_hold_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [ADDR_WIDTH-1:0] C_ONE_A = ADDR_WIDTH'(1);
  localparam logic [16:0]           C_DEPTH = 17'(DEPTH);

  logic [2:0]            state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH-1:0] widx_q, widx_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [7:0]            csum_q, csum_d;
  logic [31:0]           asm_q, asm_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic                  w_accept;
  logic [15:0]           w_len;
  logic                  w_len_bad;
  logic                  w_last_byte;
  logic                  w_last_word;

  assign w_accept    = in_valid_i && in_ready_q;
  assign w_len       = {in_data_i, len_q[7:0]};
  assign w_len_bad   = (w_len == 16'd0) || ({1'b0, w_len} > C_DEPTH);
  assign w_last_byte = (byte_cnt_q == 2'd3);
  // Truncated len-1 is exact because len never exceeds 2**ADDR_WIDTH.
  assign w_last_word = (widx_q == (len_q[ADDR_WIDTH-1:0] - C_ONE_A));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i)  state_d = S_LEN_LO;
      S_LEN_LO: if (w_accept) state_d = S_LEN_HI;
      S_LEN_HI: if (w_accept) state_d = w_len_bad ? S_ERR : S_DATA;
      S_DATA:   if (w_accept && w_last_byte && w_last_word) state_d = S_CSUM;
      S_CSUM:   if (w_accept) state_d = (in_data_i == csum_q) ? S_DONE : S_ERR;
      S_DONE:   if (start_i)  state_d = S_LEN_LO;
      S_ERR:    if (start_i)  state_d = S_LEN_LO;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode; in_ready is registered from the next state
  always_comb begin
    cpu_hold_o = (state_q != S_DONE);
    done_o     = (state_q == S_DONE);
    error_o    = (state_q == S_ERR);
    in_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                 (state_d == S_DATA)   || (state_d == S_CSUM);
  end

  // Datapath next-state
  always_comb begin
    len_d      = len_q;
    widx_d     = widx_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if (w_accept) begin
      case (state_q)
        S_LEN_LO: len_d[7:0] = in_data_i;
        S_LEN_HI: begin
          len_d[15:8] = in_data_i;
          if (!w_len_bad) begin
            widx_d     = '0;
            byte_cnt_d = 2'd0;
            csum_d     = 8'd0;
            asm_d      = 32'd0;
          end
        end
        S_DATA: begin
          asm_d[{byte_cnt_q, 3'b000} +: 8] = in_data_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
          csum_d     = csum_q + in_data_i;
          if (w_last_byte) begin
            we_d    = 1'b1;
            addr_d  = widx_q;
            wdata_d = {in_data_i, asm_q[23:0]};
            widx_d  = widx_q + C_ONE_A;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      len_q      <= 16'd0;
      widx_q     <= '0;
      byte_cnt_q <= 2'd0;
      csum_q     <= 8'd0;
      asm_q      <= 32'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
    end else begin
      len_q      <= len_d;
      widx_q     <= widx_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// +--------------------------------------------------------------------------+
// | tb_imem_loader : directed bench for imem_loader with a write scoreboard.  |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [9:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] frame_words[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(10), .DEPTH(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_ready_o   (in_ready),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .cpu_hold_o   (cpu_hold),
    .done_o       (done),
    .error_o      (error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1ns after the edge, writes checked against the scoreboard
  task automatic tick();
    logic [9:0]  ea;
    logic [31:0] ed;
    @(posedge clk);
    #1;
    if (imem_we === 1'b1) begin
      n_cmp++;
      assert (exp_addr.size() > 0) else begin
        n_fail++;
        $error("FAIL spurious_write: observed addr 0x%0h data 0x%0h expected no write",
               imem_addr, imem_wdata);
      end
      if (exp_addr.size() > 0) begin
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(ea));
        check("wr_data", imem_wdata, ed);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit acc;
    int guard;
    acc   = 1'b0;
    guard = 0;
    in_data = b;
    while (!acc && guard < 200) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = in_valid && in_ready;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("hold_after_start", 32'(cpu_hold), 32'd1);
    check("done_after_start", 32'(done), 32'd0);
    check("err_after_start", 32'(error), 32'd0);
  endtask

  // Sends a frame built from frame_words; len overrides the word count for illegal lengths
  task automatic send_frame(input logic [15:0] len, input logic [7:0] csum_xor, input bit gaps);
    logic [7:0]  sum;
    logic [31:0] w;
    sum = 8'd0;
    pulse_start();
    send_byte(len[7:0], gaps);
    send_byte(len[15:8], gaps);
    if (len != 16'd0 && len <= 16'd1024) begin
      for (int i = 0; i < frame_words.size(); i++) begin
        w = frame_words[i];
        exp_addr.push_back(10'(i));
        exp_data.push_back(w);
        for (int k = 0; k < 4; k++) begin
          sum = sum + w[8*k +: 8];
          send_byte(w[8*k +: 8], gaps);
        end
      end
      send_byte(sum ^ csum_xor, gaps);
    end
  endtask

  task automatic expect_end(input string tag, input logic exp_done, input logic exp_err);
    int guard;
    guard = 0;
    while (done !== 1'b1 && error !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    tick();
    check({tag, "_pending_writes"}, 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic load_nominal();
    frame_words.delete();
    frame_words.push_back(32'h0010_0093);
    frame_words.push_back(32'h0020_0113);
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    tick();
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    rst = 1'b1;
    tick();
    check("idle_ready", 32'(in_ready), 32'd0);

    load_nominal();
    send_frame(16'd2, 8'h00, 1'b0);
    expect_end("nominal", 1'b1, 1'b0);

    frame_words.delete();
    frame_words.push_back(32'h0000_006F);
    send_frame(16'd1, 8'h00, 1'b0);
    expect_end("reload", 1'b1, 1'b0);

    load_nominal();
    send_frame(16'd2, 8'h01, 1'b0);
    expect_end("bad_csum", 1'b0, 1'b1);

    frame_words.delete();
    send_frame(16'd0, 8'h00, 1'b0);
    expect_end("len_zero", 1'b0, 1'b1);

    send_frame(16'd1025, 8'h00, 1'b0);
    expect_end("len_1025", 1'b0, 1'b1);

    load_nominal();
    send_frame(16'd2, 8'h00, 1'b1);
    expect_end("gaps", 1'b1, 1'b0);

    // Abandon a load after five data bytes; only word 0 reaches the memory
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    exp_addr.push_back(10'd0);
    exp_data.push_back(32'h0010_0093);
    send_byte(8'h93, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    rst = 1'b0;
    tick();
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_hold", 32'(cpu_hold), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_pending", 32'(exp_addr.size()), 32'd0);
    rst = 1'b1;
    tick();
    load_nominal();
    send_frame(16'd2, 8'h00, 1'b0);
    expect_end("after_rst", 1'b1, 1'b0);

    frame_words.delete();
    for (int i = 0; i < 1024; i++)
      frame_words.push_back({16'(i), 16'(i) ^ 16'hA5C3});
    send_frame(16'd1024, 8'h00, 1'b0);
    expect_end("len_1024", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
